// File: rtl/display_pkg.sv
// Shared constants and helpers for the multi-digit 7-segment scanner.
// Glyph patterns are active-low, ordered a..g with segment a in bit 0.
package display_pkg;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [0:6] GLYPH [16] = '{
    7'b0000001,
    7'b1001111,
    7'b0010010,
    7'b0000110,
    7'b1001100,
    7'b0100100,
    7'b0100000,
    7'b0001111,
    7'b0000000,
    7'b0000100,
    7'b0001000,
    7'b1100000,
    7'b0110001,
    7'b1000010,
    7'b0110000,
    7'b0111000
  };

  // Width able to hold 8 * refresh_cycles for the on-time product.
  function automatic int on_limit_width(input int refresh_cycles);
    return $clog2(8 * refresh_cycles + 1);
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern.
// Purely combinational lookup into the shared glyph table.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [0:6] seg
);

  assign seg = GLYPH[nibble];

endmodule

// File: rtl/multi_digit_scanner.sv
// Time-multiplexed common-anode 7-segment driver with blink,
// brightness and tear-free updates through shadow registers.
module multi_digit_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 250000,
  parameter int BLINK_FRAMES   = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [2:0]              brightness,
  input  logic                    load,
  output logic [0:6]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int OW = on_limit_width(REFRESH_CYCLES);

  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [OW-1:0] REFRESH_W  = OW'(REFRESH_CYCLES);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_en;
  logic [NUM_DIGITS-1:0]   pend_blink;
  logic                    pend_flag;

  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic [NUM_DIGITS-1:0]   sh_blink;

  logic          slot_end;
  logic          frame_end;
  logic [3:0]    cur_nib;
  logic          cur_dp;
  logic          cur_en;
  logic          cur_blink;
  logic          visible;
  logic          lit;
  logic [OW-1:0] on_limit;
  logic [0:6]    glyph;

  logic [NUM_DIGITS-1:0] an_next;
  logic [0:6]            seg_next;
  logic                  dp_next;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Slot counter and digit index; index wraps to 0 after the last digit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      if (idx == IDX_LAST)
        idx <= '0;
      else
        idx <= idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Frame pulse coincides with the index returning to 0.
  always_ff @(posedge clk) begin
    if (!reset_n)
      frame_tick <= 1'b0;
    else
      frame_tick <= frame_end;
  end

  // Blink counter advances once per frame and flips the phase on wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Pending capture: the latest load in a frame wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pend_blink <= '0;
      pend_flag  <= 1'b0;
    end else if (load) begin
      pend_val   <= value;
      pend_dp    <= dp_in;
      pend_en    <= digit_en;
      pend_blink <= blink_mask;
      pend_flag  <= 1'b1;
    end else if (frame_end) begin
      pend_flag <= 1'b0;
    end
  end

  // Shadow only changes at a frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_val   <= '0;
      sh_dp    <= '0;
      sh_en    <= '0;
      sh_blink <= '0;
    end else if (frame_end && pend_flag) begin
      sh_val   <= pend_val;
      sh_dp    <= pend_dp;
      sh_en    <= pend_en;
      sh_blink <= pend_blink;
    end
  end

  // Select the active digit; codes beyond the last digit stay blank.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blink = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = sh_val[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_en    = sh_en[i];
        cur_blink = sh_blink[i];
      end
    end
  end

  hex_to_7seg u_dec (
    .nibble (cur_nib),
    .seg    (glyph)
  );

  assign on_limit = ((OW'(brightness) + OW'(1)) * REFRESH_W) >> 3;
  assign visible  = cur_en && !(blink_phase && cur_blink);
  assign lit      = visible && (OW'(cnt) < on_limit);

  // Next pin values from the current scan state.
  always_comb begin
    an_next  = '1;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (visible) begin
      seg_next = glyph;
      dp_next  = ~cur_dp;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (idx == IW'(i)))
        an_next[i] = 1'b0;
    end
  end

  // Registered pins keep anode and segment changes glitch-free.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_multi_digit_scanner.sv
// Scoreboard bench for multi_digit_scanner (4 digits, 8-cycle slots,
// 2-frame blink): stimulus queues per-cycle pin expectations.
module tb_multi_digit_scanner;

  localparam int ND = 4;
  localparam int RC = 8;
  localparam int BF = 2;

  localparam logic [6:0] GL [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  blink_mask = '0;
  logic [2:0]  brightness = 3'd7;
  logic        load = 1'b0;
  logic [0:6]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  multi_digit_scanner #(
    .NUM_DIGITS     (ND),
    .REFRESH_CYCLES (RC),
    .BLINK_FRAMES   (BF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tid;
    int         n;
    bit         tmo;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int nt = 0;

  // Monitor: pop one expectation per cycle while any is queued.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n)
      nt <= 0;
    else if (frame_tick)
      nt <= nt + 1;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (e.tmo) begin
        miscompares++;
        $display("FAIL t%0d timeout: frame_tick=0 after 200 cycles, want 1",
                 e.tid);
      end else if (an !== e.an || seg !== e.seg || dp !== e.dp ||
                   frame_tick !== e.ft) begin
        miscompares++;
        $display("FAIL t%0d[%0d]: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b",
                 e.tid, e.n, an, seg, dp, frame_tick,
                 e.an, e.seg, e.dp, e.ft);
      end
    end
  end

  task automatic push_blank(input int tid, input int cnt);
    exp_t e;
    for (int i = 0; i < cnt; i++) begin
      e.tid = tid; e.n = i; e.tmo = 1'b0;
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic push_frame(input int tid, input logic [15:0] v,
                            input logic [3:0] en, input logic [3:0] dpm,
                            input logic [3:0] blm, input logic [2:0] br);
    exp_t e;
    bit ph;
    bit blank;
    ph = ((nt / 2) % 2) == 1;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < RC; c++) begin
        blank = !en[d] || (ph && blm[d]);
        e.tid = tid; e.n = d * RC + c; e.tmo = 1'b0;
        e.an = 4'hF;
        if (!blank && c <= int'(br))
          e.an[d] = 1'b0;
        e.seg = blank ? 7'h7F : GL[v[4*d +: 4]];
        e.dp  = blank ? 1'b1 : ~dpm[d];
        e.ft  = (d == ND - 1) && (c == RC - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic wait_tick(input int tid);
    exp_t e;
    bit got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (frame_tick)
        got = 1'b1;
    end
    if (!got) begin
      e.tid = tid; e.n = 0; e.tmo = 1'b1;
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic frame(input int tid, input logic [15:0] v,
                       input logic [3:0] en, input logic [3:0] dpm,
                       input logic [3:0] blm, input logic [2:0] br);
    wait_tick(tid);
    brightness = br;
    @(posedge clk);
    push_frame(tid, v, en, dpm, blm, br);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en,
                         input logic [3:0] dpm, input logic [3:0] blm);
    @(negedge clk);
    value = v; digit_en = en; dp_in = dpm; blink_mask = blm;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && q.size() > 0; k++)
      @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    push_blank(0, 3);
    drain();
    @(negedge clk);
    reset_n = 1'b1;

    do_load(16'h1234, 4'hF, 4'h0, 4'h0);
    frame(1, 16'h1234, 4'hF, 4'h0, 4'h0, 3'd7);

    repeat (3) @(negedge clk);
    do_load(16'hABCD, 4'hF, 4'h0, 4'h0);
    do_load(16'h5678, 4'hF, 4'h0, 4'h0);
    frame(2, 16'h5678, 4'hF, 4'h0, 4'h0, 3'd7);

    frame(3, 16'h5678, 4'hF, 4'h0, 4'h0, 3'd0);
    frame(3, 16'h5678, 4'hF, 4'h0, 4'h0, 3'd3);

    do_load(16'h5678, 4'hF, 4'h0, 4'b0001);
    for (int f = 0; f < 4; f++)
      frame(4, 16'h5678, 4'hF, 4'h0, 4'b0001, 3'd7);

    do_load(16'h5678, 4'b1010, 4'b0010, 4'h0);
    frame(5, 16'h5678, 4'b1010, 4'b0010, 4'h0, 3'd7);

    drain();
    repeat (4) @(negedge clk);
    do_load(16'h9999, 4'hF, 4'hF, 4'h0);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    push_blank(6, 2);
    drain();
    reset_n = 1'b1;
    frame(6, 16'h0000, 4'h0, 4'h0, 4'h0, 3'd7);

    do_load(16'hE0F9, 4'hF, 4'b1000, 4'h0);
    frame(7, 16'hE0F9, 4'hF, 4'b1000, 4'h0, 3'd7);

    drain();
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
